// File: rtl/data_mem_pkg.sv
// Shared types and defaults for the parametrised data memory controller.
package data_mem_pkg;

    typedef enum logic {ST_CLEAR, ST_READY} mem_state_t;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 8;

    // Index width for an array of 'depth' words; a one-word array still needs one bit.
    function automatic int addr_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_array.sv
// Single-port word array: synchronous write, registered read, no reset on storage.
module mem_array_1rw
    import data_mem_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 256,
    parameter int AA    = addr_bits(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic          re_i,
    input  logic [AA-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // The controller never presents an address >= DEPTH with we_i or re_i set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: valid/ready requests, one-cycle registered loads,
// zero-fill sequencer and sticky out-of-range error.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DW             = DW_DEF,
    parameter int AW             = AW_DEF,
    parameter int DEPTH          = 256,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    input  logic          clr_start,
    output logic          busy,
    output logic          err,
    input  logic          err_clr
);

    localparam int         AA      = addr_bits(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AA-1:0] LAST  = AA'(DEPTH - 1);
    localparam mem_state_t ST_RST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    mem_state_t    state_q;
    logic [AA-1:0] clr_ptr_q;
    logic          rsp_valid_q;
    logic          rd_zero_q;
    logic          err_q;

    logic          accept;
    logic          in_range;
    logic          load_acc;
    logic          arr_we;
    logic          arr_re;
    logic [AA-1:0] arr_addr;
    logic [DW-1:0] arr_wdata;
    logic [DW-1:0] arr_rdata;

    assign req_ready = (state_q == ST_READY) && !clr_start;
    assign busy      = (state_q == ST_CLEAR);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_W;
    assign load_acc  = accept && !req_write;

    always_comb begin
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_addr  = req_addr[AA-1:0];
        arr_wdata = req_wdata;
        if (state_q == ST_CLEAR) begin
            arr_we    = 1'b1;
            arr_addr  = clr_ptr_q;
            arr_wdata = '0;
        end else if (accept && in_range) begin
            arr_we = req_write;
            arr_re = !req_write;
        end
    end

    mem_array_1rw #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AA    (AA)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (arr_addr),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    // rd_zero_q masks the array's read register: it reads as zero after reset
    // and after an out-of-range load, and otherwise holds the last loaded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RST;
            clr_ptr_q   <= '0;
            rsp_valid_q <= 1'b0;
            rd_zero_q   <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= load_acc;
            if (load_acc) begin
                rd_zero_q <= !in_range;
            end
            if (accept && !in_range) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
            if (state_q == ST_CLEAR) begin
                if (clr_ptr_q == LAST) begin
                    state_q   <= ST_READY;
                    clr_ptr_q <= '0;
                end else begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                end
            end else if (clr_start) begin
                state_q <= ST_CLEAR;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rd_zero_q ? '0 : arr_rdata;
    assign err       = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised and directed checks of data_mem_ctrl against a word-level memory model.
module tb_data_mem_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 200;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          clr_start = 1'b0;
    logic          busy;
    logic          err;
    logic          err_clr = 1'b0;

    data_mem_ctrl #(
        .DW             (DW),
        .AW             (AW),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .clr_start (clr_start),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: whole-array view, remaining clear cycles, error flag, last response.
    logic [DW-1:0] m_mem [256];
    int            m_clr_left;
    logic          m_err;
    logic          m_rv;
    logic [DW-1:0] m_rd;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_zero();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
    endtask

    task automatic model_reset();
        m_clr_left = DEPTH;
        m_err      = 1'b0;
        m_rv       = 1'b0;
        m_rd       = '0;
        model_zero();
    endtask

    // Called #1 after a rising edge; returns #1 after the next rising edge.
    task automatic step(input logic v, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic cs, input logic ec);
        logic exp_ready, acc, inr;
        logic nrv;
        logic [DW-1:0] nrd;
        req_valid = v; req_write = w; req_addr = a; req_wdata = d;
        clr_start = cs; err_clr = ec;
        #1;
        exp_ready = (m_clr_left == 0) && !cs;
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_clr_left != 0));
        acc = v && exp_ready;
        inr = int'(a) < DEPTH;
        nrv = 1'b0;
        nrd = m_rd;
        if (m_clr_left > 0) begin
            m_clr_left--;
        end else if (cs) begin
            m_clr_left = DEPTH;
            model_zero();
        end else if (acc) begin
            if (w) begin
                if (inr) m_mem[a] = d;
            end else begin
                nrv = 1'b1;
                nrd = inr ? m_mem[a] : '0;
            end
        end
        if (acc && !inr) m_err = 1'b1;
        else if (ec) m_err = 1'b0;
        m_rv = nrv;
        m_rd = nrd;
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        check("rsp_rdata", 32'(rsp_rdata), 32'(m_rd));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; clr_start = 1'b0; err_clr = 1'b0;
        #1;
        model_reset();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Counts busy cycles through the model-checked step; bounded so a stuck clear still ends.
    task automatic count_clear(input string tag);
        int cnt = 0;
        while (busy && cnt < 4 * DEPTH) begin
            idle();
            cnt++;
        end
        check(tag, 32'(cnt), 32'(DEPTH));
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        count_clear("clear_len_reset");
        check("ready_after_clear", 32'(req_ready), 32'd1);

        step(1'b1, 1'b0, 8'h7F, '0, 1'b0, 1'b0);
        check("load_7f_zero", 32'(rsp_rdata), 32'h00);

        step(1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h10, '0, 1'b0, 1'b0);
        check("st_ld_same_addr", 32'(rsp_rdata), 32'hA5);
        idle();
        check("rsp_pulse_one", 32'(rsp_valid), 32'd0);
        check("rdata_hold", 32'(rsp_rdata), 32'hA5);

        step(1'b1, 1'b1, 8'd1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd2, 8'h22, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'd3, 8'h33, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd1, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd2, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd3, '0, 1'b0, 1'b0);
        check("b2b_last", 32'(rsp_rdata), 32'h33);

        step(1'b1, 1'b1, 8'd210, 8'hFF, 1'b0, 1'b0);
        check("oor_store_err", 32'(err), 32'd1);
        step(1'b1, 1'b0, 8'd210, '0, 1'b0, 1'b0);
        check("oor_load_zero", 32'(rsp_rdata), 32'h00);
        step(1'b1, 1'b0, 8'd82, '0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd199, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        check("err_sticky", 32'(err), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        check("err_cleared", 32'(err), 32'd0);
        step(1'b1, 1'b0, 8'd200, '0, 1'b0, 1'b1);
        check("err_set_wins", 32'(err), 32'd1);

        step(1'b1, 1'b1, 8'd5, 8'h55, 1'b1, 1'b0);
        count_clear("clear_len_cmd");
        step(1'b1, 1'b0, 8'd5, '0, 1'b0, 1'b0);
        check("clr_beats_store", 32'(rsp_rdata), 32'h00);

        step(1'b1, 1'b1, 8'd7, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) idle();
        do_reset();
        count_clear("clear_len_restart");

        step(1'b1, 1'b1, 8'd9, 8'h99, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd9, '0, 1'b0, 1'b0);
        check("inflight_pre", 32'(rsp_valid), 32'd1);
        do_reset();
        count_clear("clear_len_inflight");

        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 255))
                                            : AW'($urandom_range(0, 15));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, a,
                 DW'($urandom), $urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
